// File: rtl/square_wave_meter.sv
`default_nettype none
// ============================================================================
// Module   : square_wave_meter
// Brief    : Measures an external square wave. Synchronises sig_in, then
//            reports period and high time (in clk cycles) of each completed
//            period with a one-cycle valid strobe. Flags loss of signal when
//            no rising edge arrives for 2^CNT_W-1 cycles.
//            Optional build macro METER_AVG_EN: outputs become the average of
//            the last four measurements, and valid/locked wait until four
//            measurements have been collected.
// Revision : 1.0 - initial release
// ============================================================================
module square_wave_meter #(
    parameter int CNT_W       = 26,
    parameter int SYNC_STAGES = 2     // must be 2 or more
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,   // waiting for a reference rising edge
        ST_MEASURE = 1'b1    // reference edge seen, next rise completes a period
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_prev;
    logic                   w_s;
    logic                   w_rise;
    logic [CNT_W-1:0]       r_pcnt;
    logic [CNT_W-1:0]       r_hcnt;
    logic                   w_pcnt_sat;
    logic                   w_hcnt_sat;
    logic                   w_capture;
    logic                   w_to_set;
    logic                   w_to_clr;
    logic                   w_publish;
    logic [CNT_W-1:0]       w_period_new;
    logic [CNT_W-1:0]       w_high_new;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_s & ~r_s_prev;
    assign w_pcnt_sat = (r_pcnt == c_cnt_max);
    assign w_hcnt_sat = (r_hcnt == c_cnt_max);

    // Synchroniser chain and one-cycle-delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_s_prev <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_prev <= w_s;
        end
    end

    // Period and high-time counters: restart at 1 on a rise, else saturate upward
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (w_rise) begin
            r_pcnt <= c_cnt_one;
            r_hcnt <= c_cnt_one;
        end else begin
            if (!w_pcnt_sat) begin
                r_pcnt <= r_pcnt + c_cnt_one;
            end
            if (w_s && !w_hcnt_sat) begin
                r_hcnt <= r_hcnt + c_cnt_one;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, capture request and timeout control; a rise always beats saturation
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_to_set     = 1'b0;
        w_to_clr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_rise) begin
            w_to_clr = 1'b1;
        end else if (w_pcnt_sat) begin
            w_to_set     = 1'b1;
            w_state_next = ST_IDLE;
        end
    end

`ifdef METER_AVG_EN
    // Four-measurement window: the incoming sample plus the three held here
    localparam int c_sum_w = CNT_W + 2;

    logic [CNT_W-1:0]   r_hist_p [3];   // index 0 is the most recent
    logic [CNT_W-1:0]   r_hist_h [3];
    logic [1:0]         r_nmeas;        // stored samples, saturates at 3
    logic [c_sum_w-1:0] w_psum;
    logic [c_sum_w-1:0] w_hsum;

    assign w_psum = c_sum_w'(r_pcnt) + c_sum_w'(r_hist_p[0])
                  + c_sum_w'(r_hist_p[1]) + c_sum_w'(r_hist_p[2]);
    assign w_hsum = c_sum_w'(r_hcnt) + c_sum_w'(r_hist_h[0])
                  + c_sum_w'(r_hist_h[1]) + c_sum_w'(r_hist_h[2]);

    assign w_publish    = w_capture && (r_nmeas == 2'd3);
    assign w_period_new = w_psum[c_sum_w-1:2];
    assign w_high_new   = w_hsum[c_sum_w-1:2];

    // History shift on each measurement; cleared when the signal is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmeas <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_hist_p[i] <= '0;
                r_hist_h[i] <= '0;
            end
        end else if (w_to_set) begin
            r_nmeas <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_hist_p[i] <= '0;
                r_hist_h[i] <= '0;
            end
        end else if (w_capture) begin
            r_hist_p[0] <= r_pcnt;
            r_hist_p[1] <= r_hist_p[0];
            r_hist_p[2] <= r_hist_p[1];
            r_hist_h[0] <= r_hcnt;
            r_hist_h[1] <= r_hist_h[0];
            r_hist_h[2] <= r_hist_h[1];
            if (r_nmeas != 2'd3) begin
                r_nmeas <= r_nmeas + 2'd1;
            end
        end
    end
`else
    assign w_publish    = w_capture;
    assign w_period_new = r_pcnt;
    assign w_high_new   = r_hcnt;
`endif

    // Result registers, valid strobe and status levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_to_set) begin
                timeout <= 1'b1;
                locked  <= 1'b0;
            end else if (w_to_clr) begin
                timeout <= 1'b0;
            end
            if (w_publish) begin
                period    <= w_period_new;
                high_time <= w_high_new;
                valid     <= 1'b1;
                locked    <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_square_wave_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_wave_meter
// Brief    : Self-checking bench for square_wave_meter (CNT_W=8, default
//            build). Expected (period, high_time) pairs are queued from the
//            drive-side timestamps of each input rising edge and compared
//            when valid is strobed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_square_wave_meter;

    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          sig_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          timeout;
    logic          locked;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q_exp [$];

    // Drive-side reference: timestamp of the last input rise and high samples since
    int step     = 0;
    int m_last   = 0;
    int m_high   = 0;
    bit m_prev   = 1'b0;
    bit m_armed  = 1'b0;

    square_wave_meter #(
        .CNT_W       (CW),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One input sample held across one rising clock edge
    task automatic cyc(input bit v);
        int gap;
        if (v && !m_prev) begin
            gap = step - m_last;
            if (m_armed && gap <= 255) begin
                q_exp.push_back({gap[7:0], m_high[7:0]});
            end
            m_armed = 1'b1;
            m_last  = step;
            m_high  = 0;
        end
        if (v) m_high++;
        m_prev = v;
        sig_in = v;
        step++;
        @(negedge clk);
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < p; j++) begin
                cyc(j < h);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4; i++) cyc(1'b0);
        check(tag, q_exp.size(), 0);
    endtask

    // Scoreboard side: every valid must match the oldest queued expectation
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && valid) begin
            if (q_exp.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = q_exp.pop_front();
                check("period", period, e[15:8]);
                check("high_time", high_time, e[7:0]);
                check("locked_at_valid", locked, 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_locked", locked, 0);
        rst = 1'b0;

        // Square wave P=10 H=4, then 1-cycle pulses every 7 cycles
        wave(10, 4, 6);
        check("locked_after_wave", locked, 1);
        wave(7, 1, 5);
        cyc(1'b1);
        drain("drain_waves");

        // Stuck low after lock: timeout exactly when 255 cycles pass without a rise
        cyc(1'b1);
        for (int i = 1; i <= 256; i++) cyc(i < 4);
        check("to_before", timeout, 0);
        check("locked_before_to", locked, 1);
        cyc(1'b0);
        check("to_set", timeout, 1);
        check("locked_cleared", locked, 0);
        check("period_hold", period, 5);
        check("high_hold", high_time, 1);
        for (int i = 0; i < 6; i++) cyc(i < 3);
        check("to_cleared", timeout, 0);
        check("locked_after_clear", locked, 0);
        cyc(1'b1);
        drain("drain_timeout");
        check("relocked", locked, 1);

        // Rise on the very cycle the period counter saturates
        cyc(1'b1);
        for (int i = 0; i < 254; i++) cyc(i < 1);
        cyc(1'b1);
        drain("drain_sat");
        check("sat_timeout", timeout, 0);
        check("sat_period", period, 255);

        // Asynchronous reset mid-period with the input held high
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        #2;
        check("q_empty_before_rst", q_exp.size(), 0);
        rst = 1'b1;
        #1;
        check("arst_period", period, 0);
        check("arst_high", high_time, 0);
        check("arst_locked", locked, 0);
        check("arst_valid", valid, 0);
        repeat (3) @(negedge clk);
        q_exp.delete();
        m_prev  = 1'b0;
        m_armed = 1'b0;
        rst     = 1'b0;
        for (int i = 0; i < 8; i++) cyc(i < 3);
        check("locked_one_rise", locked, 0);
        wave(10, 3, 2);
        cyc(1'b1);
        drain("drain_reset");
        check("locked_end", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
